u_rca_pipe: RTL and testbench

- Parametrised, pipelined unsigned ripple-carry adder/subtractor; successor of the fixed-width combinational u_rca family.
- Splits an N-bit add into STAGES equal chunks, with the carry registered between chunks.
- Operands stream in and results stream out through valid/ready handshakes; one result per cycle at full throughput.
- Sits in arithmetic datapaths, e.g. accumulators and multiplier final adders, where a 24+ bit ripple chain misses timing.

---
 rtl/u_rca_pkg.sv | 39 +++
 rtl/u_rca_stage.sv | 97 +++++++++
 rtl/u_rca_pipe.sv | 148 ++++++++++++++
 tb/tb_u_rca_pipe.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/u_rca_pkg.sv
// u_rca_pkg: shared sizing helpers for the pipelined ripple-carry adder.
// Offsets locate each stage boundary inside the flat inter-stage buses.
package u_rca_pkg;

    localparam int unsigned DEF_N      = 24;
    localparam int unsigned DEF_STAGES = 4;

    function automatic bit chunk_ok(int unsigned n, int unsigned s);
        return (n >= 2) && (s >= 1) && (s <= n) && ((n % s) == 0);
    endfunction

    function automatic int unsigned chunk_w(int unsigned n, int unsigned s);
        return (s == 0) ? n : n / s;
    endfunction

    // Bit offset of boundary k in the skewed upper-operand bus.
    function automatic int hi_off(int n, int s, int k);
        int acc;
        int cw;
        acc = 0;
        cw  = (s == 0) ? n : n / s;
        for (int j = 0; j < k; j++) begin
            acc += n - (j + 1) * cw;
        end
        return acc;
    endfunction

    function automatic int lo_off(int n, int s, int k);
        int acc;
        int cw;
        acc = 0;
        cw  = (s == 0) ? n : n / s;
        for (int j = 0; j < k; j++) begin
            acc += (j + 1) * cw;
        end
        return acc;
    endfunction

endpackage

// File: rtl/u_rca_stage.sv
// u_rca_stage: one CW-bit ripple chunk with its pipeline registers,
// forwarding finished low sum bits and still-unused upper operand bits.
module u_rca_stage #(
    parameter int unsigned CW   = 6,
    parameter int unsigned LO_W = 0,
    parameter int unsigned HI_W = 18,
    localparam int unsigned LP  = (LO_W > 0) ? LO_W : 1,
    localparam int unsigned HP  = (HI_W > 0) ? HI_W : 1,
    localparam int unsigned OW  = LO_W + CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_en,
    input  logic          i_valid,
    input  logic          i_cin,
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    input  logic [LP-1:0] i_lo,
    input  logic [HP-1:0] i_hi_a,
    input  logic [HP-1:0] i_hi_b,
    output logic          o_valid,
    output logic          o_cout,
    output logic [OW-1:0] o_lo,
    output logic [HP-1:0] o_hi_a,
    output logic [HP-1:0] o_hi_b
);

    logic [CW-1:0] w_s;
    logic          w_c;
    logic [OW-1:0] w_lo_nx;
    logic          r_valid;
    logic          r_cout;
    logic [OW-1:0] r_lo;

    // Full-adder chain, LSB first.
    always_comb begin
        logic v_c;
        v_c = i_cin;
        w_s = '0;
        for (int i = 0; i < CW; i++) begin
            w_s[i] = i_a[i] ^ i_b[i] ^ v_c;
            v_c    = (i_a[i] & i_b[i]) | (v_c & (i_a[i] ^ i_b[i]));
        end
        w_c = v_c;
    end

    if (LO_W > 0) begin : g_lo
        assign w_lo_nx = {w_s, i_lo};
    end else begin : g_nolo
        logic w_unused_lo;
        assign w_unused_lo = ^i_lo;
        assign w_lo_nx     = w_s;
    end

    // Data only moves with a valid beat so the output holds its last result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_cout  <= 1'b0;
            r_lo    <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_cout <= w_c;
                r_lo   <= w_lo_nx;
            end
        end
    end

    if (HI_W > 0) begin : g_hi
        logic [HP-1:0] r_hi_a;
        logic [HP-1:0] r_hi_b;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_hi_a <= '0;
                r_hi_b <= '0;
            end else if (i_en && i_valid) begin
                r_hi_a <= i_hi_a;
                r_hi_b <= i_hi_b;
            end
        end

        assign o_hi_a = r_hi_a;
        assign o_hi_b = r_hi_b;
    end else begin : g_nohi
        logic w_unused_hi;
        assign w_unused_hi = ^{i_hi_a, i_hi_b};
        assign o_hi_a      = '0;
        assign o_hi_b      = '0;
    end

    assign o_valid = r_valid;
    assign o_cout  = r_cout;
    assign o_lo    = r_lo;

endmodule

// File: rtl/u_rca_pipe.sv
// u_rca_pipe: N-bit unsigned add/sub split into STAGES ripple chunks,
// carry registered between chunks, valid/ready with a global stall.
module u_rca_pipe
    import u_rca_pkg::*;
#(
    parameter int unsigned N      = DEF_N,
    parameter int unsigned STAGES = DEF_STAGES,
    localparam int unsigned CW    = chunk_w(N, STAGES)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic         in_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N:0]   out_sum
);

    if (!chunk_ok(N, STAGES)) begin : g_bad
        $error("u_rca_pipe: need N>=2, 1<=STAGES<=N, N%%STAGES==0");
    end

    logic         w_adv;
    logic [N-1:0] w_b;

    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;
    // Subtract as A + ~B + 1; the +1 is the stage-0 carry-in.
    assign w_b      = in_b ^ {N{in_sub}};

    if (STAGES == 1) begin : g_one
        logic w_unused_ha;
        logic w_unused_hb;

        u_rca_stage #(
            .CW  (N),
            .LO_W(0),
            .HI_W(0)
        ) u_st (
            .clk    (clk),
            .rst    (rst),
            .i_en   (w_adv),
            .i_valid(in_valid),
            .i_cin  (in_sub),
            .i_a    (in_a),
            .i_b    (w_b),
            .i_lo   (1'b0),
            .i_hi_a (1'b0),
            .i_hi_b (1'b0),
            .o_valid(out_valid),
            .o_cout (out_sum[N]),
            .o_lo   (out_sum[N-1:0]),
            .o_hi_a (w_unused_ha),
            .o_hi_b (w_unused_hb)
        );
    end else begin : g_multi
        localparam int HT = hi_off(N, STAGES, STAGES - 1);
        localparam int LT = lo_off(N, STAGES, STAGES - 1);

        logic [HT-1:0]     w_ha;
        logic [HT-1:0]     w_hb;
        logic [LT-1:0]     w_lo;
        logic [STAGES-1:0] w_v;
        logic [STAGES-1:0] w_c;

        for (genvar k = 0; k < STAGES; k++) begin : g_st
            localparam int LO  = k * CW;
            localparam int HI  = N - (k + 1) * CW;
            localparam int LP  = (LO > 0) ? LO : 1;
            localparam int HP  = (HI > 0) ? HI : 1;
            localparam int OHO = hi_off(N, STAGES, k);
            localparam int OLO = lo_off(N, STAGES, k);
            localparam int IHO = (k > 0) ? hi_off(N, STAGES, k - 1) : 0;
            localparam int ILO = (k > 0) ? lo_off(N, STAGES, k - 1) : 0;

            logic [CW-1:0]    w_ia;
            logic [CW-1:0]    w_ib;
            logic [LP-1:0]    w_ilo;
            logic [HP-1:0]    w_iha;
            logic [HP-1:0]    w_ihb;
            logic [HP-1:0]    w_oha;
            logic [HP-1:0]    w_ohb;
            logic [LO+CW-1:0] w_olo;
            logic             w_iv;
            logic             w_ic;

            if (k == 0) begin : g_in
                assign w_ia  = in_a[CW-1:0];
                assign w_ib  = w_b[CW-1:0];
                assign w_ilo = '0;
                assign w_iha = in_a[N-1:CW];
                assign w_ihb = w_b[N-1:CW];
                assign w_iv  = in_valid;
                assign w_ic  = in_sub;
            end else begin : g_mid
                assign w_ia  = w_ha[IHO +: CW];
                assign w_ib  = w_hb[IHO +: CW];
                assign w_ilo = w_lo[ILO +: LO];
                assign w_iv  = w_v[k-1];
                assign w_ic  = w_c[k-1];
                if (HI > 0) begin : g_skew
                    assign w_iha = w_ha[IHO+CW +: HI];
                    assign w_ihb = w_hb[IHO+CW +: HI];
                end else begin : g_top
                    assign w_iha = '0;
                    assign w_ihb = '0;
                end
            end

            u_rca_stage #(
                .CW  (CW),
                .LO_W(LO),
                .HI_W(HI)
            ) u_st (
                .clk    (clk),
                .rst    (rst),
                .i_en   (w_adv),
                .i_valid(w_iv),
                .i_cin  (w_ic),
                .i_a    (w_ia),
                .i_b    (w_ib),
                .i_lo   (w_ilo),
                .i_hi_a (w_iha),
                .i_hi_b (w_ihb),
                .o_valid(w_v[k]),
                .o_cout (w_c[k]),
                .o_lo   (w_olo),
                .o_hi_a (w_oha),
                .o_hi_b (w_ohb)
            );

            if (k == STAGES - 1) begin : g_out
                logic w_unused_oh;
                assign w_unused_oh = ^{w_oha, w_ohb};
                assign out_sum     = {w_c[k], w_olo};
                assign out_valid   = w_v[k];
            end else begin : g_fwd
                assign w_lo[OLO +: LO+CW] = w_olo;
                assign w_ha[OHO +: HI]    = w_oha;
                assign w_hb[OHO +: HI]    = w_ohb;
            end
        end
    end

endmodule

// File: tb/tb_u_rca_pipe.sv
// tb_u_rca_pipe: random and directed checks of u_rca_pipe against
// a plain-arithmetic add/sub model, at 24/4, 8/1 and 8/8.
module tb_u_rca_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v24, rdy24, s24, ov24, ordy24;
    logic [23:0] a24, b24;
    logic [24:0] sum24;

    logic        v8, s8, ordy8, rdy1, rdy8, ov1, ov8;
    logic [7:0]  a8, b8;
    logic [8:0]  sum1, sum8;

    int n_chk  = 0;
    int n_fail = 0;
    int acc24  = 0;

    logic [24:0] q24[$];
    logic [8:0]  q1[$];
    logic [8:0]  q8[$];

    logic [23:0] ta[128];
    logic [23:0] tbv[128];
    logic        ts[128];

    u_rca_pipe #(.N(24), .STAGES(4)) dut24 (
        .clk(clk), .rst(rst), .in_valid(v24), .in_ready(rdy24),
        .in_a(a24), .in_b(b24), .in_sub(s24), .out_valid(ov24),
        .out_ready(ordy24), .out_sum(sum24)
    );

    u_rca_pipe #(.N(8), .STAGES(1)) dut8s1 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy1),
        .in_a(a8), .in_b(b8), .in_sub(s8), .out_valid(ov1),
        .out_ready(ordy8), .out_sum(sum1)
    );

    u_rca_pipe #(.N(8), .STAGES(8)) dut8s8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
        .in_a(a8), .in_b(b8), .in_sub(s8), .out_valid(ov8),
        .out_ready(ordy8), .out_sum(sum8)
    );

    // Bit N of a subtraction is "no borrow", i.e. A >= B.
    function automatic logic [24:0] ref24(logic [23:0] a, logic [23:0] b, logic s);
        logic [23:0] d;
        d = a - b;
        if (s) return {(a >= b), d};
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [8:0] ref8(logic [7:0] a, logic [7:0] b, logic s);
        logic [7:0] d;
        d = a - b;
        if (s) return {(a >= b), d};
        return {1'b0, a} + {1'b0, b};
    endfunction

    always @(posedge clk) begin
        if (!rst && v24 && rdy24) begin
            q24.push_back(ref24(a24, b24, s24));
            acc24++;
        end
        if (!rst && v8 && rdy1) q1.push_back(ref8(a8, b8, s8));
        if (!rst && v8 && rdy8) q8.push_back(ref8(a8, b8, s8));
    end

    task automatic gen_beats(int nb);
        for (int i = 0; i < nb; i++) begin
            ta[i]  = 24'($urandom);
            tbv[i] = 24'($urandom);
            ts[i]  = 1'($urandom_range(0, 1));
            if (i % 13 == 0) tbv[i] = ta[i];
            if (i % 11 == 0) ta[i] = 24'hFFFFFF;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if (ov24 !== 1'b0) begin n_fail++; $display("FAIL reset_ov24: got %b want 0", ov24); end
        n_chk++;
        if (sum24 !== 25'h0) begin n_fail++; $display("FAIL reset_sum24: got %h want 0", sum24); end
        n_chk++;
        if (rdy24 !== 1'b1) begin n_fail++; $display("FAIL reset_rdy24: got %b want 1", rdy24); end
        n_chk++;
        if (ov1 !== 1'b0 || sum1 !== 9'h0) begin
            n_fail++; $display("FAIL reset_s1: got v=%b s=%h want 0/0", ov1, sum1);
        end
        n_chk++;
        if (ov8 !== 1'b0 || sum8 !== 9'h0) begin
            n_fail++; $display("FAIL reset_s8: got v=%b s=%h want 0/0", ov8, sum8);
        end
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (ov24 !== 1'b0 || rdy24 !== 1'b1) begin
            n_fail++; $display("FAIL idle_after_reset: got v=%b r=%b want 0/1", ov24, rdy24);
        end
    endtask

    task automatic test_directed();
        logic [23:0] da[3] = '{24'hFFFFFF, 24'h000010, 24'h123456};
        logic [23:0] db[3] = '{24'h000001, 24'h000020, 24'h023456};
        logic        ds[3] = '{1'b0, 1'b1, 1'b1};
        logic [24:0] de[3] = '{25'h1000000, 25'h0FFFFF0, 25'h1100000};
        int lat;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a24 = da[i]; b24 = db[i]; s24 = ds[i]; v24 = 1'b1; ordy24 = 1'b1;
            lat = 0;
            for (int c = 1; c <= 12; c++) begin
                @(negedge clk);
                if (c == 1) v24 = 1'b0;
                if (ov24 === 1'b1) begin lat = c; break; end
            end
            n_chk++;
            if (lat != 4) begin n_fail++; $display("FAIL dir%0d_latency: got %0d want 4", i, lat); end
            n_chk++;
            if (sum24 !== de[i]) begin n_fail++; $display("FAIL dir%0d_sum: got %h want %h", i, sum24, de[i]); end
            @(negedge clk);
            n_chk++;
            if (ov24 !== 1'b0) begin n_fail++; $display("FAIL dir%0d_pulse: got %b want 0", i, ov24); end
            n_chk++;
            if (sum24 !== de[i]) begin n_fail++; $display("FAIL dir%0d_hold: got %h want %h", i, sum24, de[i]); end
        end
        q24.delete();
    endtask

    task automatic test_stream();
        int base, got, first, last, k;
        logic [24:0] exp;
        gen_beats(100);
        q24.delete();
        base = acc24; got = 0; first = -1; last = -1;
        ordy24 = 1'b1;
        for (int c = 0; c < 300 && got < 100; c++) begin
            @(negedge clk);
            if (ov24 === 1'b1) begin
                n_chk++;
                if (q24.size() == 0) begin
                    n_fail++; $display("FAIL stream_extra: got %h want none", sum24);
                end else begin
                    exp = q24.pop_front();
                    if (sum24 !== exp) begin
                        n_fail++; $display("FAIL stream_sum%0d: got %h want %h", got, sum24, exp);
                    end
                end
                got++;
                if (first < 0) first = c;
                last = c;
            end
            k = acc24 - base;
            if (k < 100) begin
                a24 = ta[k]; b24 = tbv[k]; s24 = ts[k]; v24 = 1'b1;
            end else begin
                v24 = 1'b0;
            end
        end
        v24 = 1'b0;
        n_chk++;
        if (got != 100) begin n_fail++; $display("FAIL stream_count: got %0d want 100", got); end
        n_chk++;
        if (first != 4) begin n_fail++; $display("FAIL stream_fill: got %0d want 4", first); end
        n_chk++;
        if (last - first != 99) begin n_fail++; $display("FAIL stream_rate: got %0d want 99", last - first); end
    endtask

    task automatic test_backpressure();
        int base, got, k, stall_left;
        logic stall;
        logic [24:0] exp, held;
        gen_beats(16);
        q24.delete();
        base = acc24; got = 0; stall_left = 5; held = '0;
        for (int c = 0; c < 400 && got < 16; c++) begin
            @(negedge clk);
            stall  = (ov24 === 1'b1) && got >= 3 && stall_left > 0;
            ordy24 = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            if (stall) begin
                if (stall_left == 5) begin
                    held = sum24;
                end else begin
                    n_chk++;
                    if (sum24 !== held || ov24 !== 1'b1) begin
                        n_fail++; $display("FAIL bp_hold: got %h/%b want %h/1", sum24, ov24, held);
                    end
                end
                n_chk++;
                if (rdy24 !== 1'b0) begin n_fail++; $display("FAIL bp_ready: got %b want 0", rdy24); end
                stall_left--;
            end else if (ov24 === 1'b1 && ordy24) begin
                n_chk++;
                if (q24.size() == 0) begin
                    n_fail++; $display("FAIL bp_extra: got %h want none", sum24);
                end else begin
                    exp = q24.pop_front();
                    if (sum24 !== exp) begin
                        n_fail++; $display("FAIL bp_sum%0d: got %h want %h", got, sum24, exp);
                    end
                end
                got++;
            end
            k = acc24 - base;
            if (k < 16) begin
                a24 = ta[k]; b24 = tbv[k]; s24 = ts[k]; v24 = 1'b1;
            end else begin
                v24 = 1'b0;
            end
        end
        v24 = 1'b0; ordy24 = 1'b1;
        n_chk++;
        if (got != 16) begin n_fail++; $display("FAIL bp_count: got %0d want 16", got); end
        n_chk++;
        if (stall_left != 0) begin n_fail++; $display("FAIL bp_stalled: got %0d left want 0", stall_left); end
        n_chk++;
        if (q24.size() != 0) begin n_fail++; $display("FAIL bp_lost: got %0d queued want 0", q24.size()); end
    endtask

    task automatic test_reset_mid();
        int stale, lat;
        ordy24 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a24 = 24'(i + 5); b24 = 24'(3 * i); s24 = i[0]; v24 = 1'b1;
        end
        @(posedge clk);
        #2;
        n_chk++;
        if (ov24 !== 1'b1) begin n_fail++; $display("FAIL rm_pre: got %b want 1", ov24); end
        rst = 1'b1; v24 = 1'b0;
        #1;
        n_chk++;
        if (ov24 !== 1'b0 || sum24 !== 25'h0) begin
            n_fail++; $display("FAIL rm_async: got %b/%h want 0/0", ov24, sum24);
        end
        @(negedge clk);
        rst = 1'b0;
        q24.delete();
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (ov24 !== 1'b0) stale++;
        end
        n_chk++;
        if (stale != 0) begin n_fail++; $display("FAIL rm_stale: got %0d want 0", stale); end
        a24 = 24'd1; b24 = 24'd2; s24 = 1'b0; v24 = 1'b1;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) v24 = 1'b0;
            if (ov24 === 1'b1) begin lat = c; break; end
        end
        n_chk++;
        if (lat != 4 || sum24 !== 25'd3) begin
            n_fail++; $display("FAIL rm_after: got lat=%0d sum=%h want 4/3", lat, sum24);
        end
        q24.delete();
    endtask

    task automatic test_corner8();
        int got1, got8, f1, f8;
        logic [8:0] exp;
        q1.delete(); q8.delete();
        got1 = 0; got8 = 0; f1 = -1; f8 = -1;
        ordy8 = 1'b1;
        for (int c = 0; c < 65536 + 40 && (got1 < 65536 || got8 < 65536); c++) begin
            @(negedge clk);
            if (ov1 === 1'b1) begin
                n_chk++;
                exp = (q1.size() != 0) ? q1.pop_front() : 9'h1FF;
                if (sum1 !== exp) begin
                    n_fail++;
                    if (n_fail < 20) $display("FAIL s1_sum%0d: got %h want %h", got1, sum1, exp);
                end
                if (f1 < 0) f1 = c;
                got1++;
            end
            if (ov8 === 1'b1) begin
                n_chk++;
                exp = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
                if (sum8 !== exp) begin
                    n_fail++;
                    if (n_fail < 20) $display("FAIL s8_sum%0d: got %h want %h", got8, sum8, exp);
                end
                if (f8 < 0) f8 = c;
                got8++;
            end
            if (c < 65536) begin
                a8 = c[15:8]; b8 = c[7:0]; s8 = 1'($urandom_range(0, 1)); v8 = 1'b1;
            end else begin
                v8 = 1'b0;
            end
        end
        v8 = 1'b0;
        n_chk++;
        if (f1 != 1) begin n_fail++; $display("FAIL s1_latency: got %0d want 1", f1); end
        n_chk++;
        if (f8 != 8) begin n_fail++; $display("FAIL s8_latency: got %0d want 8", f8); end
        n_chk++;
        if (got1 != 65536 || got8 != 65536) begin
            n_fail++; $display("FAIL s_count: got %0d/%0d want 65536", got1, got8);
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        v24 = 1'b0; s24 = 1'b0; ordy24 = 1'b1; a24 = '0; b24 = '0;
        v8 = 1'b0; s8 = 1'b0; ordy8 = 1'b1; a8 = '0; b8 = '0;
        test_reset();
        test_directed();
        test_stream();
        test_backpressure();
        test_reset_mid();
        test_corner8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
